// File: rtl/uart_tx_top.sv
// uart_tx_top -- 8-bit UART transmitter.
//
// Serialises one byte per accepted `send` request onto `uart_tx`:
// start bit (0), 8 data bits LSB first, optional parity bit, STOP_BITS stop
// bits (1). Every bit is held for CLKS_PER_BIT = CLK_FREQ/BAUD clocks.
//
// Handshake (request/ready): a request is accepted on any cycle where
// ready=1 (state IDLE) and send=1. `data` is sampled only on that cycle.
// While ready=0, send is ignored and nothing is queued. The producer must
// hold or re-issue send.
//
// Configuration macro: UART_TX_PARITY_EN
//   defined   -> PARITY state between DATA and STOP. PARITY_ODD selects the
//                parity sense (0 = even, 1 = odd).
//   undefined -> 8N1 / 8N2 frame, no PARITY_ODD parameter.
//
// Ports:
//   clk      in   1  system clock, rising edge
//   rst      in   1  synchronous reset, active-high (aborts any frame)
//   data     in   8  byte to send, sampled on the accept cycle
//   send     in   1  transmit request, level-sampled every cycle
//   uart_tx  out  1  serial line, idle/mark = 1, registered
//   ready    out  1  1 = idle, a request will be accepted, registered
module uart_tx_top #(
  parameter int CLK_FREQ  = 12_000_000,
  parameter int BAUD      = 9_600,
  parameter int STOP_BITS = 1
`ifdef UART_TX_PARITY_EN
  ,
  parameter int PARITY_ODD = 0
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       send,
  output logic       uart_tx,
  output logic       ready
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  // Guard against a zero-width timer when CLKS_PER_BIT is 1.
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]    state;
  logic [TW-1:0] timer;
  // Data bit index in DATA, stop bit index in STOP.
  logic [2:0]    bit_idx;
  // Byte latched on accept. It is indexed rather than shifted, so the
  // complete byte stays available for parity.
  logic [7:0]    data_r;
  logic          bit_done;

  assign bit_done = (timer == TIMER_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      timer   <= '0;
      bit_idx <= '0;
      data_r  <= '0;
      uart_tx <= 1'b1;
      ready   <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          timer   <= '0;
          bit_idx <= '0;
          if (send) begin
            data_r  <= data;
            state   <= S_START;
            uart_tx <= 1'b0;
            ready   <= 1'b0;
          end
        end

        S_START: begin
          if (bit_done) begin
            timer   <= '0;
            bit_idx <= '0;
            state   <= S_DATA;
            uart_tx <= data_r[0];
          end else begin
            timer <= timer + 1'b1;
          end
        end

        S_DATA: begin
          if (bit_done) begin
            timer <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= S_PARITY;
              uart_tx <= (^data_r) ^ 1'(PARITY_ODD);
`else
              state   <= S_STOP;
              uart_tx <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              uart_tx <= data_r[bit_idx + 3'd1];
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_done) begin
            timer   <= '0;
            bit_idx <= '0;
            state   <= S_STOP;
            uart_tx <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
`endif

        S_STOP: begin
          uart_tx <= 1'b1;
          if (bit_done) begin
            timer <= '0;
            if (bit_idx == LAST_STOP) begin
              bit_idx <= '0;
              state   <= S_IDLE;
              ready   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        default: begin
          state   <= S_IDLE;
          timer   <= '0;
          bit_idx <= '0;
          uart_tx <= 1'b1;
          ready   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_top.sv
// tb_uart_tx_top -- directed bench for uart_tx_top at default parameters
// (1250 clocks per bit, 1 stop bit). Line values are checked at the first
// and last clock of every bit, and ready is checked mid-bit.
module tb_uart_tx_top;

  localparam int CPB = 12_000_000 / 9_600;
`ifdef UART_TX_PARITY_EN
  localparam int PODD = 0;
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = 8'h00;
  logic       send = 1'b0;
  logic       uart_tx;
  logic       ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_top #(
    .CLK_FREQ (12_000_000),
    .BAUD     (9_600),
    .STOP_BITS(1)
`ifdef UART_TX_PARITY_EN
    ,
    .PARITY_ODD(PODD)
`endif
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .data   (data),
    .send   (send),
    .uart_tx(uart_tx),
    .ready  (ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Sends byte b with a one-clock send pulse and checks the whole frame.
  // inject_bit >= 0: at mid-bit of that frame bit, pulse send with data=0xFF.
  // abort_bit  >= 0: at mid-bit of that frame bit, pulse rst and stop.
  task automatic run_frame(input logic [7:0] b, input int inject_bit,
                           input int abort_bit);
    logic exp_bits [NB];
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[1 + i] = b[i];
`ifdef UART_TX_PARITY_EN
    exp_bits[9]  = (^b) ^ 1'(PODD);
    exp_bits[10] = 1'b1;
`else
    exp_bits[9]  = 1'b1;
`endif
    data = b;
    send = 1'b1;
    tick();
    send = 1'b0;
    chk($sformatf("ready_low_after_accept_%h", b), ready, 1'b0);
    for (int k = 0; k < NB; k++) begin
      for (int c = 0; c < CPB; c++) begin
        if (c == 0 || c == CPB - 1)
          chk($sformatf("line_%h_bit%0d_clk%0d", b, k, c), uart_tx, exp_bits[k]);
        if (c == CPB / 2)
          chk($sformatf("ready_busy_%h_bit%0d", b, k), ready, 1'b0);
        if (k == inject_bit && c == CPB / 2) begin
          data = 8'hFF;
          send = 1'b1;
        end
        if (k == inject_bit && c == CPB / 2 + 1) send = 1'b0;
        if (k == abort_bit && c == CPB / 2) begin
          rst = 1'b1;
          tick();
          rst = 1'b0;
          chk("abort_line_idle", uart_tx, 1'b1);
          chk("abort_ready", ready, 1'b1);
          return;
        end
        tick();
      end
    end
    chk($sformatf("ready_after_frame_%h", b), ready, 1'b1);
    chk($sformatf("line_idle_after_frame_%h", b), uart_tx, 1'b1);
  endtask

  task automatic check_idle(input string tag, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      if (c % 250 == 0) begin
        chk($sformatf("%s_line_%0d", tag, c), uart_tx, 1'b1);
        chk($sformatf("%s_ready_%0d", tag, c), ready, 1'b1);
      end
      tick();
    end
  endtask

  initial begin
    // Reset held for two clocks.
    rst = 1'b1;
    tick();
    tick();
    chk("reset_line", uart_tx, 1'b1);
    chk("reset_ready", ready, 1'b1);
    rst = 1'b0;
    check_idle("post_reset", 500);

    // 'H' = 0x48 -> 0,0,0,0,1,0,0,1,0,1.
    run_frame(8'h48, -1, -1);
    check_idle("after_H", 20);

    // 'i' = 0x69 -> 0,1,0,0,1,0,1,1,0,1.
    run_frame(8'h69, -1, -1);
    check_idle("after_i", 20);

    // A request during data bit 3 (frame bit 4) must be ignored: this
    // frame is unchanged and no second frame follows.
    run_frame(8'h69, 4, -1);
    check_idle("no_second_frame", 3000);

    // Reset during data bit 4 (frame bit 5) aborts the frame.
    run_frame(8'hA3, -1, 5);
    check_idle("after_abort", 20);

    // A clean full frame after the abort.
    run_frame(8'h55, -1, -1);

`ifdef UART_TX_PARITY_EN
    // 0x07 has three set bits: even parity bit 1, odd parity bit 0.
    run_frame(8'h07, -1, -1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #(100_000 * 10);
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
